fifo_rd_ptr_ctrl: RTL and testbench

//  Read-side pointer controller of the async FIFO; owns read pointer (binary+Gray), accepts pops.

---
 rtl/fifo_ptr_pkg.sv | 20 ++
 rtl/fifo_rd_ptr_ctrl_if.sv | 36 +++
 rtl/gray_to_bin.sv | 17 +
 rtl/ptr_sync.sv | 29 ++
 rtl/fifo_rd_ptr_ctrl.sv | 98 +++++++++
 tb/tb_fifo_rd_ptr_ctrl.sv | 210 +++++++++++++++++++++
 6 files changed

// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: shared pointer definitions for the async FIFO read- and
// write-side pointer controllers.
//   PTR_AW  : default RAM address width (pointers carry one extra wrap bit)
//   DEPTH   : FIFO depth for the default address width
//   ptr_t   : pointer type for the default address width
//   bin2gray: binary to reflected-Gray conversion. It works on a 32-bit
//             container; callers zero-extend and truncate, which leaves the
//             low bits unchanged.
package fifo_ptr_pkg;

  localparam int unsigned PTR_AW = 4;
  localparam int unsigned DEPTH  = 2 ** PTR_AW;

  typedef logic [PTR_AW:0] ptr_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_rd_ptr_ctrl_if.sv
// fifo_rd_ptr_ctrl_if: read-side pointer controller bus.
//   wr_gptr_i      : write Gray pointer from the write domain (asynchronous)
//   rd_en_i        : pop request from the consumer
//   rd_ack_o       : pop accepted this cycle
//   rd_addr_o      : RAM read address
//   rd_gptr_o      : registered read Gray pointer to the write domain
//   empty_o        : FIFO empty
//   fill_o         : entries held
//   almost_empty_o : fill_o at or below the almost-empty threshold
//   err_o          : sticky pointer-protocol error
// The slave modport is the controller; the master modport is its environment.
interface fifo_rd_ptr_ctrl_if #(
  parameter int unsigned AW = 4
);

  logic [AW:0]   wr_gptr_i;
  logic          rd_en_i;
  logic          rd_ack_o;
  logic [AW-1:0] rd_addr_o;
  logic [AW:0]   rd_gptr_o;
  logic          empty_o;
  logic [AW:0]   fill_o;
  logic          almost_empty_o;
  logic          err_o;

  modport slave (
    input  wr_gptr_i, rd_en_i,
    output rd_ack_o, rd_addr_o, rd_gptr_o, empty_o, fill_o, almost_empty_o, err_o
  );

  modport master (
    output wr_gptr_i, rd_en_i,
    input  rd_ack_o, rd_addr_o, rd_gptr_o, empty_o, fill_o, almost_empty_o, err_o
  );

endinterface

// File: rtl/gray_to_bin.sv
// GrayToBin: combinational reflected-Gray to binary decoder.
//   g : Gray-coded input
//   b : binary output
// Binary bit i is the XOR of all Gray bits at or above position i.
module GrayToBin #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] g,
  output logic [N-1:0] b
);

  always_comb begin
    b = '0;
    for (int i = 0; i < int'(N); i++) b[i] = ^(g >> i);
  end

endmodule

// File: rtl/ptr_sync.sv
// ptr_sync: generic flop-chain synchroniser with a synchronous active-low reset.
//   clk, rst_n : destination-domain clock and reset
//   d          : asynchronous input (Gray-coded, so at most one bit moves)
//   q          : output of the last stage
module ptr_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift register; stage 0 is the metastability-capture flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// fifo_rd_ptr_ctrl: read-side pointer controller of the async FIFO.
// It owns the read pointer in binary and Gray form and accepts pops. It
// synchronises the write Gray pointer and produces registered empty, fill
// level and almost-empty flags.
//   clk, rst_n : read-domain clock and synchronous active-low reset
//   bus        : fifo_rd_ptr_ctrl_if.slave (write pointer in, pop handshake,
//                RAM address, read Gray pointer out, status flags)
// Optional feature: define FIFO_RD_PTR_CHECK_EN to enable the sticky err_o
// protocol check. It flags a synchronised write pointer that moves more than
// one bit, or a fill level above the depth. Otherwise err_o is tied to 0.
module fifo_rd_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned AW          = PTR_AW,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fifo_rd_ptr_ctrl_if.slave       bus
);

  localparam int unsigned PW = AW + 1;
  localparam logic [AW:0] AE_LIM = PW'(AE_THRESH);

  logic [AW:0] rbin, rgray, wsync, wbin;
  logic [AW:0] rbin_nxt, rgray_nxt, fill_nxt, fill_q;
  logic        empty_q, ae_q, ack;

  ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wsync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.wr_gptr_i),
    .q     (wsync)
  );

  GrayToBin #(.N(PW)) u_wdec (
    .g (wsync),
    .b (wbin)
  );

  // Next-pointer and next-status computation; a pop is never taken while empty.
  always_comb begin
    ack       = bus.rd_en_i & ~empty_q;
    rbin_nxt  = rbin + PW'(ack);
    rgray_nxt = PW'(bin2gray(32'(rbin_nxt)));
    fill_nxt  = wbin - rbin_nxt;
  end

  // Pointer and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbin    <= '0;
      rgray   <= '0;
      empty_q <= 1'b1;
      fill_q  <= '0;
      ae_q    <= 1'b1;
    end else begin
      rbin    <= rbin_nxt;
      rgray   <= rgray_nxt;
      empty_q <= (rgray_nxt == wsync);
      fill_q  <= fill_nxt;
      ae_q    <= (fill_nxt <= AE_LIM);
    end
  end

  assign bus.rd_ack_o       = ack;
  assign bus.rd_addr_o      = rbin[AW-1:0];
  assign bus.rd_gptr_o      = rgray;
  assign bus.empty_o        = empty_q;
  assign bus.fill_o         = fill_q;
  assign bus.almost_empty_o = ae_q;

`ifdef FIFO_RD_PTR_CHECK_EN
  localparam logic [AW:0] DEPTH_LIM = PW'(2 ** AW);

  logic [AW:0] wsync_prev, wdiff;
  logic        err_q;

  // More than one set bit in wdiff means a non-Gray step crossed the domain.
  always_comb wdiff = wsync ^ wsync_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wsync_prev <= '0;
      err_q      <= 1'b0;
    end else begin
      wsync_prev <= wsync;
      if (((wdiff & (wdiff - PW'(1))) != '0) || (fill_nxt > DEPTH_LIM)) err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// tb_fifo_rd_ptr_ctrl: self-checking bench for fifo_rd_ptr_ctrl (AW=4,
// SYNC_STAGES=2, AE_THRESH=2). The reference model tracks total writes and
// pops as plain integers. The write count reaches the reader through a delay
// queue of SYNC_STAGES entries.
module tb_fifo_rd_ptr_ctrl;

  localparam int unsigned AW = 4;
  localparam int SYNC = 2;
  localparam int AE = 2;

  logic clk;
  logic rst_n;

  fifo_rd_ptr_ctrl_if #(.AW(AW)) bus ();

  fifo_rd_ptr_ctrl #(.AW(AW), .SYNC_STAGES(SYNC), .AE_THRESH(AE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state.
  int wr_cnt, rd_cnt, m_fill;
  bit m_empty;
  int syncq[$];
  int last_ack;

  function automatic int gray5(input int n);
    int m;
    m = n % 32;
    return m ^ (m >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    wr_cnt  = 0;
    rd_cnt  = 0;
    m_fill  = 0;
    m_empty = 1'b1;
    syncq.delete();
    for (int i = 0; i < SYNC; i++) syncq.push_back(0);
  endtask

  // One clock of stimulus; checks the handshake before the edge and all
  // registered outputs after it against the model.
  task automatic step(input bit rd, input bit winc);
    int exp_ack;
    @(negedge clk);
    if (winc) wr_cnt++;
    bus.rd_en_i   = rd;
    bus.wr_gptr_i = 5'(gray5(wr_cnt));
    #1;
    exp_ack  = (rd && !m_empty) ? 1 : 0;
    last_ack = int'(bus.rd_ack_o);
    chk("ack", last_ack, exp_ack);
    @(posedge clk);
    rd_cnt += exp_ack;
    m_fill  = syncq[SYNC-1] - rd_cnt;
    m_empty = (m_fill == 0);
    syncq.push_front(wr_cnt);
    void'(syncq.pop_back());
    #1;
    chk("empty", int'(bus.empty_o), int'(m_empty));
    chk("fill", int'(bus.fill_o), m_fill);
    chk("almost_empty", int'(bus.almost_empty_o), (m_fill <= AE) ? 1 : 0);
    chk("rd_addr", int'(bus.rd_addr_o), rd_cnt % 16);
    chk("rd_gptr", int'(bus.rd_gptr_o), gray5(rd_cnt));
    chk("err", int'(bus.err_o), 0);
  endtask

  // Three reset cycles with pop requests and junk write pointers, then release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rd_en_i = 1'b1;
    repeat (3) begin
      bus.wr_gptr_i = 5'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_empty", int'(bus.empty_o), 1);
    chk("rst_fill", int'(bus.fill_o), 0);
    chk("rst_gptr", int'(bus.rd_gptr_o), 0);
    chk("rst_addr", int'(bus.rd_addr_o), 0);
    chk("rst_ae", int'(bus.almost_empty_o), 1);
    chk("rst_err", int'(bus.err_o), 0);
    chk("rst_ack", int'(bus.rd_ack_o), 0);
    @(negedge clk);
    bus.rd_en_i   = 1'b0;
    bus.wr_gptr_i = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit winc;
    bit rd;
    int ack;
    int empty;
    int fill;
    int gptr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int iter;
    int exp_err;
    rst_n = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.wr_gptr_i = '0;
    model_reset();

    // One write, wait out the sync latency, one pop, then five pops while empty.
    tbl[0] = '{1'b1, 1'b0, 0, 1, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 0, 1, 0, 0};
    tbl[2] = '{1'b0, 1'b0, 0, 0, 1, 0};
    tbl[3] = '{1'b0, 1'b1, 1, 1, 0, 1};
    for (int i = 4; i < 9; i++) tbl[i] = '{1'b0, 1'b1, 0, 1, 0, 1};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rd, tbl[i].winc);
      chk($sformatf("tbl%0d_ack", i), last_ack, tbl[i].ack);
      chk($sformatf("tbl%0d_empty", i), int'(bus.empty_o), tbl[i].empty);
      chk($sformatf("tbl%0d_fill", i), int'(bus.fill_o), tbl[i].fill);
      chk($sformatf("tbl%0d_gptr", i), int'(bus.rd_gptr_o), tbl[i].gptr);
    end
    chk("tbl_addr", int'(bus.rd_addr_o), 1);

    // Fill to 16 entries (write pointer 11000), then drain through the wrap.
    do_reset();
    repeat (16) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    chk("full_fill", int'(bus.fill_o), 16);
    chk("full_ae", int'(bus.almost_empty_o), 0);
    chk("full_empty", int'(bus.empty_o), 0);
    iter = 0;
    while (rd_cnt < 32 && iter < 200) begin
      step(1'b1, (wr_cnt < 32) && (wr_cnt - rd_cnt < 16));
      if (rd_cnt == 31) chk("wrap_gptr31", int'(bus.rd_gptr_o), 16);
      if (rd_cnt == 32) begin
        chk("wrap_gptr0", int'(bus.rd_gptr_o), 0);
        chk("wrap_addr0", int'(bus.rd_addr_o), 0);
      end
      iter++;
    end
    chk("wrap_reached", rd_cnt, 32);
    step(1'b0, 1'b0);
    chk("wrap_empty", int'(bus.empty_o), 1);

    // Reach fill 3, then pop and write every cycle.
    repeat (3) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    chk("simul_start_fill", int'(bus.fill_o), 3);
    repeat (12) begin
      step(1'b1, 1'b1);
      chk("simul_empty", int'(bus.empty_o), 0);
      chk("simul_fill_range", (bus.fill_o >= 1 && bus.fill_o <= 3) ? 1 : 0, 1);
    end

    // Random traffic; the writer never exceeds the depth.
    repeat (400) step(($urandom % 4) != 0, (($urandom % 2) != 0) && (wr_cnt - rd_cnt < 16));

    // Two-bit jump of the write pointer, then reset in the middle of the run.
`ifdef FIFO_RD_PTR_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    do_reset();
    @(negedge clk);
    bus.wr_gptr_i = 5'b00011;
    repeat (4) @(posedge clk);
    #1;
    chk("chk_err", int'(bus.err_o), exp_err);
    chk("chk_fill", int'(bus.fill_o), 2);
    chk("chk_empty", int'(bus.empty_o), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("chk_err_sticky", int'(bus.err_o), exp_err);
    do_reset();
    step(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
